// File: rtl/uart_alu_frame_ctrl.sv
// UART frame controller for a byte-serial ALU.
// Receives A, B (NBYTES each, LSB byte first) and an opcode byte, then strobes the ALU.
// The result is sent back byte by byte, LSB first, through a handshaked UART transmitter.
// A partially received frame is abandoned after TIMEOUT_CYCLES idle clocks.
// Bytes that arrive while the block is executing or transmitting are dropped and flagged.
module uart_alu_frame_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_busy,
  output logic [NB_DATA-1:0] o_operand_a,
  output logic [NB_DATA-1:0] o_operand_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic               o_alu_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_frame_err,
  output logic               o_overrun
);

  localparam int NBYTES = NB_DATA / 8;
  localparam int NB_K   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_K-1:0]   K_LAST   = NB_K'(NBYTES - 1);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RX_A    = 3'd0,
    S_RX_B    = 3'd1,
    S_RX_OP   = 3'd2,
    S_EXEC    = 3'd3,
    S_TX_LOAD = 3'd4,
    S_TX_HOLD = 3'd5,
    S_TX_WAIT = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [NB_K-1:0]     k_r, k_s;
  logic [NB_CNT-1:0]   cnt_r, cnt_s;
  logic [NB_DATA-1:0]  operand_a_r, operand_b_r, result_r;
  logic [NB_OP-1:0]    opcode_r;
  logic [7:0]          tx_data_r;
  logic                alu_valid_r, overrun_r;

  logic                rx_phase_s, active_s, timeout_s, last_byte_s, tx_start_s;
  logic [7:0]          byte_s;

  // Frame-progress decode: which bytes are expected, whether the idle timer is armed.
  always_comb begin
    rx_phase_s  = (state_r == S_RX_A) || (state_r == S_RX_B) || (state_r == S_RX_OP);
    // The timer only runs once at least one byte of the frame has been taken.
    active_s    = rx_phase_s && !((state_r == S_RX_A) && (k_r == '0));
    // A byte landing on the expiry cycle wins over the timeout.
    timeout_s   = active_s && !i_rx_done && (cnt_r == CNT_LAST);
    last_byte_s = (k_r == K_LAST);
    tx_start_s  = (state_r == S_TX_LOAD) && !i_tx_busy;
    byte_s      = result_r[{k_r, 3'b000} +: 8];
  end

  // Next-state, byte index and idle-timer logic.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    if (timeout_s) begin
      state_s = S_RX_A;
      k_s     = '0;
    end else begin
      case (state_r)
        S_RX_A: begin
          if (i_rx_done && last_byte_s) begin
            state_s = S_RX_B;
            k_s     = '0;
          end else if (i_rx_done) begin
            k_s     = k_r + NB_K'(1);
          end else begin
            k_s     = k_r;
          end
        end
        S_RX_B: begin
          if (i_rx_done && last_byte_s) begin
            state_s = S_RX_OP;
            k_s     = '0;
          end else if (i_rx_done) begin
            k_s     = k_r + NB_K'(1);
          end else begin
            k_s     = k_r;
          end
        end
        S_RX_OP: begin
          if (i_rx_done) begin
            state_s = S_EXEC;
          end else begin
            state_s = S_RX_OP;
          end
        end
        S_EXEC: begin
          state_s = S_TX_LOAD;
          k_s     = '0;
        end
        S_TX_LOAD: begin
          if (!i_tx_busy) begin
            state_s = S_TX_HOLD;
          end else begin
            state_s = S_TX_LOAD;
          end
        end
        // One idle cycle gives the transmitter time to raise busy.
        S_TX_HOLD: begin
          state_s = S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (!i_tx_busy && last_byte_s) begin
            state_s = S_RX_A;
            k_s     = '0;
          end else if (!i_tx_busy) begin
            state_s = S_TX_LOAD;
            k_s     = k_r + NB_K'(1);
          end else begin
            state_s = S_TX_WAIT;
          end
        end
        default: begin
          state_s = S_RX_A;
          k_s     = '0;
        end
      endcase
    end

    if (!active_s || i_rx_done || timeout_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + NB_CNT'(1);
    end
  end

  // Control state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= S_RX_A;
      k_r     <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      cnt_r   <= cnt_s;
    end
  end

  // Operand/opcode capture, result capture, transmit byte latch and status pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      operand_a_r <= '0;
      operand_b_r <= '0;
      opcode_r    <= '0;
      result_r    <= '0;
      tx_data_r   <= 8'h00;
      alu_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (i_rx_done) begin
        case (state_r)
          S_RX_A:  operand_a_r[{k_r, 3'b000} +: 8] <= i_rx_data;
          S_RX_B:  operand_b_r[{k_r, 3'b000} +: 8] <= i_rx_data;
          S_RX_OP: opcode_r <= i_rx_data[NB_OP-1:0];
          default: opcode_r <= opcode_r;
        endcase
      end
      if (state_r == S_EXEC) begin
        result_r <= i_alu_result;
      end
      if (tx_start_s) begin
        tx_data_r <= byte_s;
      end
      // Goes high exactly while the FSM sits in S_EXEC.
      alu_valid_r <= (state_r == S_RX_OP) && i_rx_done;
      overrun_r   <= i_rx_done && !rx_phase_s;
    end
  end

  assign o_operand_a = operand_a_r;
  assign o_operand_b = operand_b_r;
  assign o_opcode    = opcode_r;
  assign o_alu_valid = alu_valid_r;
  assign o_tx_start  = tx_start_s;
  // The new byte is presented during the start pulse and then held by the latch.
  assign o_tx_data   = tx_start_s ? byte_s : tx_data_r;
  assign o_frame_err = timeout_s;
  assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed bench for uart_alu_frame_ctrl: an 8-bit and a 16-bit instance,
// each with a small transmitter model that answers tx_start with a busy window.
module tb_uart_alu_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0] rxd8 = 8'h00, a8, b8, alu8 = 8'h00, txd8;
  logic       rxv8 = 1'b0, busy8 = 1'b0, av8, txs8, fe8, ov8;
  logic [5:0] op8;
  // 16-bit instance
  logic [7:0]  rxd16 = 8'h00, txd16;
  logic [15:0] a16, b16, alu16 = 16'h0000;
  logic        rxv16 = 1'b0, busy16 = 1'b0, av16, txs16, fe16, ov16;
  logic [5:0]  op16;

  uart_alu_frame_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(100)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rxd8), .i_rx_done(rxv8),
    .i_alu_result(alu8), .i_tx_busy(busy8), .o_operand_a(a8), .o_operand_b(b8),
    .o_opcode(op8), .o_alu_valid(av8), .o_tx_data(txd8), .o_tx_start(txs8),
    .o_frame_err(fe8), .o_overrun(ov8));

  uart_alu_frame_ctrl #(.NB_DATA(16), .NB_OP(6), .TIMEOUT_CYCLES(100)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rxd16), .i_rx_done(rxv16),
    .i_alu_result(alu16), .i_tx_busy(busy16), .o_operand_a(a16), .o_operand_b(b16),
    .o_opcode(op16), .o_alu_valid(av16), .o_tx_data(txd16), .o_tx_start(txs16),
    .o_frame_err(fe16), .o_overrun(ov16));

  int ncomp = 0;
  int nfail = 0;

  // Monitor state
  int nstart8 = 0, nfe8 = 0, nov8 = 0, dbl8 = 0, bcnt8 = 0;
  int nstart16 = 0, dbl16 = 0, bad16 = 0, bcnt16 = 0;
  logic [7:0] log8 = 8'h00;
  logic [7:0] log16 [2];
  bit pend8 = 0, pend16 = 0, seen_hi16 = 0;
  logic p_av8 = 0, p_txs8 = 0, p_fe8 = 0, p_ov8 = 0;
  logic p_av16 = 0, p_txs16 = 0, p_fe16 = 0, p_ov16 = 0;

  // 8-bit side: pulse counting, back-to-back pulse detection, transmitter model.
  always @(negedge clk) begin
    #2;
    if ((av8 && p_av8) || (txs8 && p_txs8) || (fe8 && p_fe8) || (ov8 && p_ov8)) dbl8 = dbl8 + 1;
    if (txs8) begin nstart8 = nstart8 + 1; log8 = txd8; end
    if (fe8) nfe8 = nfe8 + 1;
    if (ov8) nov8 = nov8 + 1;
    p_av8 = av8; p_txs8 = txs8; p_fe8 = fe8; p_ov8 = ov8;
    if (bcnt8 > 0) begin bcnt8 = bcnt8 - 1; if (bcnt8 == 0) busy8 = 1'b0; end
    if (pend8) begin busy8 = 1'b1; bcnt8 = 6; pend8 = 0; end
    if (txs8) pend8 = 1;
  end

  // 16-bit side: same model, plus a check that each later start follows a busy window.
  always @(negedge clk) begin
    #2;
    if ((av16 && p_av16) || (txs16 && p_txs16) || (fe16 && p_fe16) || (ov16 && p_ov16)) dbl16 = dbl16 + 1;
    if (txs16) begin
      if (nstart16 > 0 && !seen_hi16) bad16 = bad16 + 1;
      if (nstart16 < 2) log16[nstart16] = txd16;
      nstart16 = nstart16 + 1;
      seen_hi16 = 0;
    end
    if (busy16) seen_hi16 = 1;
    p_av16 = av16; p_txs16 = txs16; p_fe16 = fe16; p_ov16 = ov16;
    if (bcnt16 > 0) begin bcnt16 = bcnt16 - 1; if (bcnt16 == 0) busy16 = 1'b0; end
    if (pend16) begin busy16 = 1'b1; bcnt16 = 6; pend16 = 0; end
    if (txs16) pend16 = 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp = ncomp + 1;
    assert (obs === exp) else begin
      nfail = nfail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] b);
    tick(); rxd8 = b; rxv8 = 1'b1;
    tick(); rxv8 = 1'b0;
  endtask

  task automatic send16(input logic [7:0] b);
    tick(); rxd16 = b; rxv16 = 1'b1;
    tick(); rxv16 = 1'b0;
  endtask

  task automatic wait_start8(input string tag, input int n0);
    for (int i = 0; i < 40 && nstart8 == n0; i++) tick();
    chk(tag, 64'(nstart8 - n0), 64'd1);
  endtask

  initial begin
    int n0, f0, o0;
    // Reset state
    repeat (3) tick();
    chk("reset_dut8_outputs", {a8, b8, op8, av8, txd8, txs8, fe8, ov8}, 64'd0);
    chk("reset_dut16_outputs", {a16, b16, op16, av16, txd16, txs16, fe16, ov16}, 64'd0);
    rst = 1'b0;
    tick();

    // 16-bit frame, two result bytes LSB first
    alu16 = 16'hABCE;
    send16(8'hCD); send16(8'hAB); send16(8'h01); send16(8'h00);
    chk("w16_no_valid_before_op", {63'd0, av16}, 64'd0);
    send16(8'h20);
    chk("w16_alu_valid", {63'd0, av16}, 64'd1);
    chk("w16_operands", {a16, b16, 2'b00, op16}, {16'hABCD, 16'h0001, 8'h20});
    tick();
    chk("w16_valid_one_cycle", {63'd0, av16}, 64'd0);
    for (int i = 0; i < 80 && nstart16 < 2; i++) tick();
    chk("w16_two_starts", 64'(nstart16), 64'd2);
    chk("w16_tx_bytes", {log16[0], log16[1]}, 64'hCEAB);
    chk("w16_start_after_busy", 64'(bad16), 64'd0);
    repeat (10) tick();
    chk("w16_no_extra_start", 64'(nstart16), 64'd2);

    // Basic 8-bit frame
    alu8 = 8'h46;
    n0 = nstart8;
    send8(8'h12); send8(8'h34);
    chk("b8_no_valid_before_op", {63'd0, av8}, 64'd0);
    send8(8'h05);
    chk("b8_alu_valid_latency", {63'd0, av8}, 64'd1);
    chk("b8_operands", {a8, b8, 2'b00, op8}, 64'h123405);
    tick();
    chk("b8_valid_one_cycle", {63'd0, av8}, 64'd0);
    wait_start8("b8_start_seen", n0);
    chk("b8_tx_byte", 64'(log8), 64'h46);
    repeat (12) tick();
    chk("b8_single_start", 64'(nstart8 - n0), 64'd1);
    chk("b8_tx_data_held", 64'(txd8), 64'h46);

    // Inter-byte timeout
    f0 = nfe8;
    send8(8'h11);
    repeat (98) tick();
    chk("to_no_err_early", {63'd0, fe8}, 64'd0);
    tick();
    chk("to_err_at_100", {63'd0, fe8}, 64'd1);
    chk("to_regs_kept", {a8, b8, 2'b00, op8}, 64'h113405);
    tick();
    chk("to_err_one_cycle", {63'd0, fe8}, 64'd0);
    tick();
    chk("to_err_count", 64'(nfe8 - f0), 64'd1);
    alu8 = 8'h06;
    n0 = nstart8;
    send8(8'h01); send8(8'h02); send8(8'h03);
    chk("to_fresh_valid", {63'd0, av8}, 64'd1);
    chk("to_fresh_operands", {a8, b8, 2'b00, op8}, 64'h010203);
    wait_start8("to_fresh_start", n0);
    chk("to_fresh_tx", 64'(log8), 64'h06);
    repeat (12) tick();

    // Byte on the timeout cycle is accepted; byte during transmit is dropped
    f0 = nfe8;
    o0 = nov8;
    alu8 = 8'h43;
    send8(8'h21);
    repeat (99) tick();
    rxd8 = 8'h22; rxv8 = 1'b1;
    #1;
    chk("race_no_frame_err", {63'd0, fe8}, 64'd0);
    tick(); rxv8 = 1'b0;
    send8(8'h03);
    chk("race_valid", {63'd0, av8}, 64'd1);
    chk("race_operands", {a8, b8, 2'b00, op8}, 64'h212203);
    chk("race_err_count", 64'(nfe8 - f0), 64'd0);
    n0 = nstart8;
    wait_start8("ovr_start_seen", n0);
    chk("ovr_tx_byte", 64'(log8), 64'h43);
    tick(); tick();
    rxd8 = 8'h77; rxv8 = 1'b1;
    tick(); rxv8 = 1'b0;
    chk("ovr_pulse", {63'd0, ov8}, 64'd1);
    chk("ovr_tx_data_kept", 64'(txd8), 64'h43);
    tick();
    chk("ovr_pulse_one_cycle", {63'd0, ov8}, 64'd0);
    repeat (10) tick();
    chk("ovr_count", 64'(nov8 - o0), 64'd1);
    chk("ovr_single_start", 64'(nstart8 - n0), 64'd1);
    alu8 = 8'h99;
    n0 = nstart8;
    send8(8'h31); send8(8'h32); send8(8'hC7);
    chk("ovr_next_frame", {a8, b8, 2'b00, op8}, 64'h313207);
    wait_start8("ovr_next_start", n0);
    repeat (12) tick();

    // Reset mid-frame and mid-transmit
    send8(8'h55); send8(8'h66);
    rst = 1'b1;
    #1;
    chk("rst_midframe_zero", {a8, b8, op8, av8, txd8, txs8, fe8, ov8}, 64'd0);
    tick(); rst = 1'b0;
    tick();
    alu8 = 8'h15;
    n0 = nstart8;
    send8(8'h0A); send8(8'h0B); send8(8'h01);
    chk("rst_frame_valid", {63'd0, av8}, 64'd1);
    chk("rst_frame_operands", {a8, b8, 2'b00, op8}, 64'h0A0B01);
    wait_start8("rst_frame_start", n0);
    chk("rst_frame_tx", 64'(log8), 64'h15);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_midtx_zero", {a8, b8, op8, av8, txd8, txs8, fe8, ov8}, 64'd0);
    tick(); rst = 1'b0;
    repeat (10) tick();
    alu8 = 8'h07;
    n0 = nstart8;
    send8(8'h01); send8(8'h02); send8(8'h03);
    chk("rst_after_tx_operands", {a8, b8, 2'b00, op8}, 64'h010203);
    wait_start8("rst_after_tx_start", n0);
    chk("rst_after_tx_byte", 64'(log8), 64'h07);
    repeat (12) tick();

    chk("pulses_single_cycle_8", 64'(dbl8), 64'd0);
    chk("pulses_single_cycle_16", 64'(dbl16), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
